stack_call_ctrl: RTL and testbench

//  Initiator side of the Stack push/pop interface. Sequences CALL/RET/IRQ/RETI for the 8-bit core.
//  - CALL/IRQ push the return address; IRQ also pushes the flags.
//  - RET/RETI pop them back and drive a PC load (plus a flag load for RETI).
//  - Sits between the control unit / PC register and the Stack; tracks stack depth to block overflow and underflow.

---
 rtl/stack_call_ctrl_pkg.sv | 37 +++
 rtl/stack_call_ctrl_if.sv | 41 ++++
 rtl/stack_call_ctrl_depth.sv | 40 ++++
 rtl/stack_call_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_stack_call_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_call_ctrl_pkg.sv
// Shared types and constants for the CALL/RET/IRQ/RETI stack sequencer.
// Holds the FSM state encoding, operation tags and flag-byte layout.
package stack_call_ctrl_pkg;

  localparam int DEPTH_DEFAULT = 255;

  localparam int FLAG_Z_BIT = 0;
  localparam int FLAG_C_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_PC,
    ST_PUSH_FLG,
    ST_POP_FLG,
    ST_CAP_FLG,
    ST_POP_PC,
    ST_CAP_PC,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    OP_CALL,
    OP_RET,
    OP_IRQ,
    OP_RETI
  } op_t;

  // Flag byte as it sits on the stack: {6'b0, C, Z}
  function automatic logic [7:0] packFlags(input logic z, input logic c);
    logic [7:0] f;
    f = 8'h00;
    f[FLAG_Z_BIT] = z;
    f[FLAG_C_BIT] = c;
    return f;
  endfunction

endpackage

// File: rtl/stack_call_ctrl_if.sv
// Bundle between the control unit / PC register / Stack and the sequencer.
// The master side is the sequencer itself; the slave side is its environment.
interface stack_call_ctrl_if;

  logic       Call;
  logic       Ret;
  logic       Irq;
  logic       Reti;
  logic [7:0] PC;
  logic [7:0] Target;
  logic       Zflag;
  logic       Cflag;
  logic [7:0] StackDataout;

  logic       StackRead;
  logic       StackWrite;
  logic [7:0] StackDatain;
  logic       PCload;
  logic [7:0] PCout;
  logic       FlagLoad;
  logic       Zout;
  logic       Cout;
  logic       Busy;
  logic       Done;
  logic       Overflow;
  logic       Underflow;
  logic [7:0] Depth;

  modport master (
    input  Call, Ret, Irq, Reti, PC, Target, Zflag, Cflag, StackDataout,
    output StackRead, StackWrite, StackDatain, PCload, PCout, FlagLoad,
           Zout, Cout, Busy, Done, Overflow, Underflow, Depth
  );

  modport slave (
    output Call, Ret, Irq, Reti, PC, Target, Zflag, Cflag, StackDataout,
    input  StackRead, StackWrite, StackDatain, PCload, PCout, FlagLoad,
           Zout, Cout, Busy, Done, Overflow, Underflow, Depth
  );

endinterface

// File: rtl/stack_call_ctrl_depth.sv
// Stack occupancy counter: follows push/pop strobes, saturates at both ends
// and pre-computes the room/content guards the sequencer checks at accept.
module stack_call_ctrl_depth
  import stack_call_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [7:0] o_depth,
  output logic       o_canPush1,
  output logic       o_canPush2,
  output logic       o_canPop1,
  output logic       o_canPop2
);

  localparam logic [7:0] MAX_DEPTH   = 8'(DEPTH);
  localparam logic [7:0] MAX_DEPTH_1 = 8'(DEPTH - 1);

  logic [7:0] r_depth;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_depth <= 8'h00;
    end else if (i_inc && !i_dec && (r_depth != MAX_DEPTH)) begin
      r_depth <= r_depth + 8'd1;
    end else if (i_dec && !i_inc && (r_depth != 8'h00)) begin
      r_depth <= r_depth - 8'd1;
    end
  end

  assign o_depth    = r_depth;
  assign o_canPush1 = (r_depth < MAX_DEPTH);
  assign o_canPush2 = (r_depth < MAX_DEPTH_1);
  assign o_canPop1  = (r_depth >= 8'd1);
  assign o_canPop2  = (r_depth >= 8'd2);

endmodule

// File: rtl/stack_call_ctrl.sv
// Initiator side of the Stack push/pop interface: sequences CALL/RET/IRQ/RETI
// for the 8-bit core, with depth tracking that refuses overflow and underflow.
module stack_call_ctrl
  import stack_call_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              Reset,
  stack_call_ctrl_if.master bus
);

  state_t     r_state;
  op_t        r_op;
  logic [7:0] r_target;
  logic [7:0] r_flagByte;
  logic [7:0] r_stackDatain;
  logic [7:0] r_pcOut;
  logic       r_stackWrite;
  logic       r_stackRead;
  logic       r_pcLoad;
  logic       r_flagLoad;
  logic       r_zOut;
  logic       r_cOut;
  logic       r_done;
  logic       r_overflow;
  logic       r_underflow;

  logic [7:0] w_retAddr;
  logic [7:0] w_flagByte;
  logic [7:0] w_depth;
  logic       w_canPush1;
  logic       w_canPush2;
  logic       w_canPop1;
  logic       w_canPop2;

  assign w_retAddr  = bus.PC + 8'd1;
  assign w_flagByte = packFlags(bus.Zflag, bus.Cflag);

  // Counts the registered strobes, so Depth settles the cycle after each byte
  stack_call_ctrl_depth #(
    .DEPTH (DEPTH)
  ) u_depth (
    .i_clk      (clk),
    .i_reset    (Reset),
    .i_inc      (r_stackWrite),
    .i_dec      (r_stackRead),
    .o_depth    (w_depth),
    .o_canPush1 (w_canPush1),
    .o_canPush2 (w_canPush2),
    .o_canPop1  (w_canPop1),
    .o_canPop2  (w_canPop2)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_CALL;
      r_target      <= 8'h00;
      r_flagByte    <= 8'h00;
      r_stackDatain <= 8'h00;
      r_pcOut       <= 8'h00;
      r_stackWrite  <= 1'b0;
      r_stackRead   <= 1'b0;
      r_pcLoad      <= 1'b0;
      r_flagLoad    <= 1'b0;
      r_zOut        <= 1'b0;
      r_cOut        <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_stackWrite <= 1'b0;
      r_stackRead  <= 1'b0;
      r_pcLoad     <= 1'b0;
      r_flagLoad   <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        // Requests are only looked at here; a refused guard goes straight to FINISH
        ST_IDLE: begin
          if (bus.Irq || bus.Call || bus.Ret || bus.Reti) begin
            r_target   <= bus.Target;
            r_flagByte <= w_flagByte;
          end
          if (bus.Irq) begin
            r_op <= OP_IRQ;
            if (w_canPush2) begin
              r_state       <= ST_PUSH_PC;
              r_stackWrite  <= 1'b1;
              r_stackDatain <= w_retAddr;
            end else begin
              r_state    <= ST_FINISH;
              r_done     <= 1'b1;
              r_overflow <= 1'b1;
            end
          end else if (bus.Call) begin
            r_op <= OP_CALL;
            if (w_canPush1) begin
              r_state       <= ST_PUSH_PC;
              r_stackWrite  <= 1'b1;
              r_stackDatain <= w_retAddr;
            end else begin
              r_state    <= ST_FINISH;
              r_done     <= 1'b1;
              r_overflow <= 1'b1;
            end
          end else if (bus.Ret) begin
            r_op <= OP_RET;
            if (w_canPop1) begin
              r_state     <= ST_POP_PC;
              r_stackRead <= 1'b1;
            end else begin
              r_state     <= ST_FINISH;
              r_done      <= 1'b1;
              r_underflow <= 1'b1;
            end
          end else if (bus.Reti) begin
            r_op <= OP_RETI;
            if (w_canPop2) begin
              r_state     <= ST_POP_FLG;
              r_stackRead <= 1'b1;
            end else begin
              r_state     <= ST_FINISH;
              r_done      <= 1'b1;
              r_underflow <= 1'b1;
            end
          end
        end
        ST_PUSH_PC: begin
          if (r_op == OP_IRQ) begin
            r_state       <= ST_PUSH_FLG;
            r_stackWrite  <= 1'b1;
            r_stackDatain <= r_flagByte;
          end else begin
            r_state  <= ST_FINISH;
            r_pcLoad <= 1'b1;
            r_pcOut  <= r_target;
            r_done   <= 1'b1;
          end
        end
        ST_PUSH_FLG: begin
          r_state  <= ST_FINISH;
          r_pcLoad <= 1'b1;
          r_pcOut  <= r_target;
          r_done   <= 1'b1;
        end
        ST_POP_FLG: begin
          r_state <= ST_CAP_FLG;
        end
        ST_CAP_FLG: begin
          r_zOut      <= bus.StackDataout[FLAG_Z_BIT];
          r_cOut      <= bus.StackDataout[FLAG_C_BIT];
          r_state     <= ST_POP_PC;
          r_stackRead <= 1'b1;
        end
        ST_POP_PC: begin
          r_state <= ST_CAP_PC;
        end
        // Stack read data is valid here, one cycle after the pop strobe
        ST_CAP_PC: begin
          r_state    <= ST_FINISH;
          r_pcOut    <= bus.StackDataout;
          r_pcLoad   <= 1'b1;
          r_flagLoad <= (r_op == OP_RETI);
          r_done     <= 1'b1;
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.StackWrite  = r_stackWrite;
  assign bus.StackRead   = r_stackRead;
  assign bus.StackDatain = r_stackDatain;
  assign bus.PCload      = r_pcLoad;
  assign bus.PCout       = r_pcOut;
  assign bus.FlagLoad    = r_flagLoad;
  assign bus.Zout        = r_zOut;
  assign bus.Cout        = r_cOut;
  assign bus.Done        = r_done;
  assign bus.Overflow    = r_overflow;
  assign bus.Underflow   = r_underflow;
  assign bus.Depth       = w_depth;
  assign bus.Busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_stack_call_ctrl.sv
// Bench for stack_call_ctrl: pairs the sequencer with a behavioural Stack and
// drives a table of operations plus hand-written overflow and reset sequences.
module tb_stack_call_ctrl;

  logic clk = 1'b0;
  logic Reset = 1'b1;

  always #5 clk = ~clk;

  stack_call_ctrl_if bus();

  stack_call_ctrl dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  // Behavioural Stack: pointer starts at 8'hFF, grows down, registered read
  logic [7:0] stackMem [0:255];
  logic [7:0] sp;

  always @(posedge clk) begin
    if (Reset) begin
      sp               <= 8'hFF;
      bus.StackDataout <= 8'h00;
    end else begin
      if (bus.StackWrite) begin
        stackMem[sp] <= bus.StackDatain;
        sp           <= sp - 8'd1;
      end
      if (bus.StackRead) begin
        bus.StackDataout <= stackMem[sp + 8'd1];
        sp               <= sp + 8'd1;
      end
    end
  end

  int posCount = 0;
  always @(posedge clk) posCount <= posCount + 1;

  int         wrCount = 0;
  int         rdCount = 0;
  int         bothCount = 0;
  int         pcLoadCount = 0;
  int         flagLoadCount = 0;
  int         doneCount = 0;
  int         doneAt = 0;
  logic [7:0] lastPcOut = 8'h00;
  logic       lastZ = 1'b0;
  logic       lastC = 1'b0;
  logic [7:0] wrLog [0:1023];

  // Observes the strobes away from the active edge
  always @(negedge clk) begin
    if (bus.StackWrite) begin
      wrLog[10'(wrCount)] = bus.StackDatain;
      wrCount++;
    end
    if (bus.StackRead) rdCount++;
    if (bus.StackWrite && bus.StackRead) bothCount++;
    if (bus.PCload) begin
      pcLoadCount++;
      lastPcOut = bus.PCout;
    end
    if (bus.FlagLoad) begin
      flagLoadCount++;
      lastZ = bus.Zout;
      lastC = bus.Cout;
    end
    if (bus.Done) begin
      doneCount++;
      doneAt = posCount;
    end
  end

  int nChecks = 0;
  int nPass = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       call, ret, irq, reti;
    logic [7:0] pc, tgt;
    logic       z, c;
    int         expLat, expWr, expRd;
    logic [7:0] expD0, expD1;
    int         expPcLoad;
    logic [7:0] expPcOut;
    int         expFlagLoad;
    logic       expZ, expC;
    logic [7:0] expDepth;
    logic       expOvf, expUnf;
  } vec_t;

  function automatic vec_t mk(
    input logic call, ret, irq, reti, input logic [7:0] pc, tgt, input logic z, c,
    input int lat, wr, rd, input logic [7:0] d0, d1, input int pcl, input logic [7:0] pcOut,
    input int fl, input logic ez, ec, input logic [7:0] depth, input logic ovf, unf);
    vec_t v;
    v.call = call; v.ret = ret; v.irq = irq; v.reti = reti;
    v.pc = pc; v.tgt = tgt; v.z = z; v.c = c;
    v.expLat = lat; v.expWr = wr; v.expRd = rd; v.expD0 = d0; v.expD1 = d1;
    v.expPcLoad = pcl; v.expPcOut = pcOut; v.expFlagLoad = fl;
    v.expZ = ez; v.expC = ec; v.expDepth = depth; v.expOvf = ovf; v.expUnf = unf;
    return v;
  endfunction

  // One request pulse, then wait (bounded) for Done; returns accept-to-Done latency
  task automatic applyStimulus(input logic call, ret, irq, reti, input logic [7:0] pc, tgt,
                               input logic z, c, output int lat);
    int d0;
    int p;
    int waited;
    @(negedge clk);
    d0 = doneCount;
    bus.Call = call; bus.Ret = ret; bus.Irq = irq; bus.Reti = reti;
    bus.PC = pc; bus.Target = tgt; bus.Zflag = z; bus.Cflag = c;
    p = posCount;
    @(negedge clk);
    bus.Call = 1'b0; bus.Ret = 1'b0; bus.Irq = 1'b0; bus.Reti = 1'b0;
    #1;
    waited = 0;
    while (doneCount == d0 && waited < 30) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (doneCount == d0) begin
      checkOutput("done timeout", 32'd0, 32'd1);
      lat = -1;
    end else begin
      lat = doneAt - p;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " Busy"}, bus.Busy, 0);
    checkOutput({tag, " Done"}, bus.Done, 0);
    checkOutput({tag, " PCload"}, bus.PCload, 0);
    checkOutput({tag, " FlagLoad"}, bus.FlagLoad, 0);
    checkOutput({tag, " StackRead"}, bus.StackRead, 0);
    checkOutput({tag, " StackWrite"}, bus.StackWrite, 0);
    checkOutput({tag, " StackDatain"}, bus.StackDatain, 0);
    checkOutput({tag, " PCout"}, bus.PCout, 0);
    checkOutput({tag, " Zout"}, bus.Zout, 0);
    checkOutput({tag, " Cout"}, bus.Cout, 0);
    checkOutput({tag, " Overflow"}, bus.Overflow, 0);
    checkOutput({tag, " Underflow"}, bus.Underflow, 0);
    checkOutput({tag, " Depth"}, bus.Depth, 0);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkResetState(tag);
    @(negedge clk);
    Reset = 1'b0;
    #1;
  endtask

  vec_t vecs [14];

  initial begin
    int         lat;
    int         w0, r0, pl0, f0, dn0;
    vec_t       v;
    logic [9:0] idx;

    bus.Call = 1'b0; bus.Ret = 1'b0; bus.Irq = 1'b0; bus.Reti = 1'b0;
    bus.PC = 8'h00; bus.Target = 8'h00; bus.Zflag = 1'b0; bus.Cflag = 1'b0;

    //              C  R  I  Ri  PC     Tgt    Z  C  lat wr rd d0     d1     pcl pcOut fl eZ eC depth  ovf unf
    vecs[0]  = mk(1, 0, 0, 0, 8'h10, 8'h80, 0, 0, 2, 1, 0, 8'h11, 8'h00, 1, 8'h80, 0, 0, 0, 8'd1, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 3, 0, 1, 8'h00, 8'h00, 1, 8'h11, 0, 0, 0, 8'd0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 8'hFF, 8'h04, 1, 0, 3, 2, 0, 8'h00, 8'h01, 1, 8'h04, 0, 0, 0, 8'd2, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 5, 0, 2, 8'h00, 8'h00, 1, 8'h00, 1, 1, 0, 8'd0, 0, 0);
    vecs[4]  = mk(0, 0, 1, 0, 8'h3A, 8'h20, 0, 1, 3, 2, 0, 8'h3B, 8'h02, 1, 8'h20, 0, 0, 0, 8'd2, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 8'h50, 8'h60, 0, 0, 2, 1, 0, 8'h51, 8'h00, 1, 8'h60, 0, 0, 0, 8'd3, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 3, 0, 1, 8'h00, 8'h00, 1, 8'h51, 0, 0, 0, 8'd2, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 8'h00, 8'h00, 1, 1, 5, 0, 2, 8'h00, 8'h00, 1, 8'h3B, 1, 0, 1, 8'd0, 0, 0);
    vecs[8]  = mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 8'd0, 0, 1);
    vecs[9]  = mk(1, 0, 0, 0, 8'h7F, 8'h01, 0, 0, 2, 1, 0, 8'h80, 8'h00, 1, 8'h01, 0, 0, 0, 8'd1, 0, 1);
    vecs[10] = mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 8'd1, 0, 1);
    vecs[11] = mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 3, 0, 1, 8'h00, 8'h00, 1, 8'h80, 0, 0, 0, 8'd0, 0, 1);
    vecs[12] = mk(1, 1, 0, 0, 8'h20, 8'h30, 0, 0, 2, 1, 0, 8'h21, 8'h00, 1, 8'h30, 0, 0, 0, 8'd1, 0, 1);
    vecs[13] = mk(1, 1, 1, 1, 8'h44, 8'h08, 1, 1, 3, 2, 0, 8'h45, 8'h03, 1, 8'h08, 0, 0, 0, 8'd3, 0, 1);

    repeat (3) @(negedge clk);
    #1;
    checkResetState("power-on");
    @(negedge clk);
    Reset = 1'b0;
    #1;

    for (int i = 0; i < 14; i++) begin
      v   = vecs[i];
      w0  = wrCount;
      r0  = rdCount;
      pl0 = pcLoadCount;
      f0  = flagLoadCount;
      dn0 = doneCount;
      applyStimulus(v.call, v.ret, v.irq, v.reti, v.pc, v.tgt, v.z, v.c, lat);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(v.expLat));
      checkOutput($sformatf("v%0d writes", i), 32'(wrCount - w0), 32'(v.expWr));
      checkOutput($sformatf("v%0d reads", i), 32'(rdCount - r0), 32'(v.expRd));
      checkOutput($sformatf("v%0d done pulses", i), 32'(doneCount - dn0), 32'd1);
      if (v.expWr >= 1) begin
        idx = 10'(w0);
        checkOutput($sformatf("v%0d push0", i), wrLog[idx], v.expD0);
      end
      if (v.expWr >= 2) begin
        idx = 10'(w0 + 1);
        checkOutput($sformatf("v%0d push1", i), wrLog[idx], v.expD1);
      end
      checkOutput($sformatf("v%0d pcload", i), 32'(pcLoadCount - pl0), 32'(v.expPcLoad));
      if (v.expPcLoad > 0) checkOutput($sformatf("v%0d pcout", i), lastPcOut, v.expPcOut);
      checkOutput($sformatf("v%0d flagload", i), 32'(flagLoadCount - f0), 32'(v.expFlagLoad));
      if (v.expFlagLoad > 0) begin
        checkOutput($sformatf("v%0d zout", i), lastZ, v.expZ);
        checkOutput($sformatf("v%0d cout", i), lastC, v.expC);
      end
      checkOutput($sformatf("v%0d depth", i), bus.Depth, v.expDepth);
      checkOutput($sformatf("v%0d overflow", i), bus.Overflow, v.expOvf);
      checkOutput($sformatf("v%0d underflow", i), bus.Underflow, v.expUnf);
      checkOutput($sformatf("v%0d busy", i), bus.Busy, 0);
    end

    doReset("post-table");

    // Reset landing while the PC byte is being captured
    applyStimulus(1, 0, 0, 0, 8'h90, 8'h10, 0, 0, lat);
    checkOutput("midreset call depth", bus.Depth, 8'd1);
    @(negedge clk);
    bus.Ret = 1'b1;
    pl0 = pcLoadCount;
    dn0 = doneCount;
    @(negedge clk);
    bus.Ret = 1'b0;
    #1;
    checkOutput("midreset pop strobe", bus.StackRead, 1);
    @(negedge clk);
    #1;
    checkOutput("midreset busy in CAP_PC", bus.Busy, 1);
    checkOutput("midreset no strobe in CAP_PC", bus.StackRead, 0);
    Reset = 1'b1;
    @(negedge clk);
    #1;
    checkResetState("midreset");
    Reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("midreset no pcload", 32'(pcLoadCount - pl0), 32'd0);
    checkOutput("midreset no done", 32'(doneCount - dn0), 32'd0);
    checkOutput("midreset depth stays 0", bus.Depth, 8'd0);

    // Irq with only one free entry
    doReset("pre-fill-254");
    for (int i = 0; i < 254; i++) applyStimulus(1, 0, 0, 0, 8'(i), 8'h00, 0, 0, lat);
    checkOutput("fill254 depth", bus.Depth, 8'd254);
    checkOutput("fill254 overflow clear", bus.Overflow, 0);
    w0  = wrCount;
    pl0 = pcLoadCount;
    applyStimulus(0, 0, 1, 0, 8'h12, 8'h34, 1, 1, lat);
    checkOutput("irq@254 latency", 32'(lat), 32'd1);
    checkOutput("irq@254 writes", 32'(wrCount - w0), 32'd0);
    checkOutput("irq@254 pcload", 32'(pcLoadCount - pl0), 32'd0);
    checkOutput("irq@254 overflow", bus.Overflow, 1);
    checkOutput("irq@254 depth", bus.Depth, 8'd254);
    applyStimulus(1, 0, 0, 0, 8'h12, 8'h34, 0, 0, lat);
    checkOutput("call@254 depth", bus.Depth, 8'd255);

    // Full stack, then one Call too many
    doReset("pre-fill-255");
    for (int i = 0; i < 255; i++) applyStimulus(1, 0, 0, 0, 8'(i), 8'h00, 0, 0, lat);
    checkOutput("fill255 depth", bus.Depth, 8'd255);
    checkOutput("fill255 overflow clear", bus.Overflow, 0);
    w0  = wrCount;
    pl0 = pcLoadCount;
    applyStimulus(1, 0, 0, 0, 8'h55, 8'h66, 0, 0, lat);
    checkOutput("call@255 latency", 32'(lat), 32'd1);
    checkOutput("call@255 writes", 32'(wrCount - w0), 32'd0);
    checkOutput("call@255 pcload", 32'(pcLoadCount - pl0), 32'd0);
    checkOutput("call@255 overflow", bus.Overflow, 1);
    checkOutput("call@255 depth", bus.Depth, 8'd255);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00, 0, 0, lat);
    checkOutput("ret after full pcout", lastPcOut, 8'hFF);
    checkOutput("ret after full depth", bus.Depth, 8'd254);
    checkOutput("overflow sticky", bus.Overflow, 1);

    checkOutput("no simultaneous strobes", 32'(bothCount), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
